// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : registered RISC-V decode stage with a two-entry skid buffer.
// Optional macro DECODE_ILLEGAL_EN builds illegal-instruction detection.
// Revision 1.0
// ============================================================================
module decode_stage #(
   parameter int XLEN  = 64,
   parameter bit RV64W = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [4:0]      rd_o,
   output logic [6:0]      op_o,
   output logic [2:0]      funct3_o,
   output logic [6:0]      funct7_o,
   output logic            r_type_o,
   output logic            i_type_o,
   output logic            s_type_o,
   output logic            b_type_o,
   output logic            u_type_o,
   output logic            j_type_o,
   output logic [XLEN-1:0] imm_o,
   output logic [XLEN-1:0] pc_o,
   output logic            illegal_o
);

   localparam bit W_EN = (XLEN == 64) && RV64W;

   typedef struct packed {
      logic [31:0]     instr;
      logic [5:0]      cls;      // {r,i,s,b,u,j}
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e state_q, state_d;
   entry_t main_q, main_d, skid_q, skid_d;
   logic   ready_q, ready_d;
   entry_t dec;
   logic   accept, pop;
   logic [63:0] imm64;

   // Immediates are formed at 64 bits and truncated so XLEN=32 needs no special case.
   always_comb begin
      dec       = '0;
      imm64     = '0;
      dec.instr = instr_i;
      dec.pc    = pc_i;
      unique case (instr_i[6:0])
         7'b0110011: dec.cls = 6'b100000;
         7'b0010011, 7'b0000011, 7'b1100111: dec.cls = 6'b010000;
         7'b0100011: dec.cls = 6'b001000;
         7'b1100011: dec.cls = 6'b000100;
         7'b0110111, 7'b0010111: dec.cls = 6'b000010;
         7'b1101111: dec.cls = 6'b000001;
         7'b0111011: dec.cls = W_EN ? 6'b100000 : 6'b000000;
         7'b0011011: dec.cls = W_EN ? 6'b010000 : 6'b000000;
         default:    dec.cls = 6'b000000;
      endcase
      unique case (1'b1)
         dec.cls[4]: imm64 = {{52{instr_i[31]}}, instr_i[31:20]};
         dec.cls[3]: imm64 = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         dec.cls[2]: imm64 = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
         dec.cls[1]: imm64 = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
         dec.cls[0]: imm64 = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
         default:    imm64 = '0;
      endcase
      dec.imm = imm64[XLEN-1:0];
`ifdef DECODE_ILLEGAL_EN
      dec.illegal = (dec.cls == 6'b000000) || (instr_i[1:0] != 2'b11);
`else
      dec.illegal = 1'b0;
`endif
   end

   assign in_ready_o  = ready_q;
   assign out_valid_o = (state_q != EMPTY);
   assign accept      = in_valid_i && ready_q;
   assign pop         = out_valid_o && out_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: if (accept) begin
            state_d = ONE;
            main_d  = dec;
         end
         ONE: begin
            if (accept && pop) begin
               main_d = dec;
            end else if (accept) begin
               state_d = TWO;
               skid_d  = dec;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) begin
         state_d = EMPTY;
      end
      ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign rs1_o     = main_q.instr[19:15];
   assign rs2_o     = main_q.instr[24:20];
   assign rd_o      = main_q.instr[11:7];
   assign op_o      = main_q.instr[6:0];
   assign funct3_o  = main_q.instr[14:12];
   assign funct7_o  = main_q.instr[31:25];
   assign r_type_o  = main_q.cls[5];
   assign i_type_o  = main_q.cls[4];
   assign s_type_o  = main_q.cls[3];
   assign b_type_o  = main_q.cls[2];
   assign u_type_o  = main_q.cls[1];
   assign j_type_o  = main_q.cls[0];
   assign imm_o     = main_q.imm;
   assign pc_o      = main_q.pc;
   assign illegal_o = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_stage : table-driven scoreboard bench for decode_stage (XLEN=64).
// Revision 1.0
// ============================================================================
module tb_decode_stage;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [5:0]  cls;
      logic [63:0] imm;
      bit          unrec;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, flush_i, in_valid_i, out_ready_i;
   logic        in_ready_o, out_valid_o;
   logic [31:0] instr_i;
   logic [63:0] pc_i;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [6:0]  op_o, funct7_o;
   logic [2:0]  funct3_o;
   logic        r_o, i_o, s_o, b_o, u_o, j_o, illegal_o;
   logic [63:0] imm_o, pc_o;

   logic        nw_in_ready, nw_out_valid, nw_r, nw_i, nw_s, nw_b, nw_u, nw_j, nw_ill;
   logic [4:0]  nw_rs1, nw_rs2, nw_rd;
   logic [6:0]  nw_op, nw_f7;
   logic [2:0]  nw_f3;
   logic [63:0] nw_imm, nw_pc;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[14];
   vec_t cur;
   vec_t q[$];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(64), .RV64W(1'b1)) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .op_o(op_o),
      .funct3_o(funct3_o), .funct7_o(funct7_o),
      .r_type_o(r_o), .i_type_o(i_o), .s_type_o(s_o),
      .b_type_o(b_o), .u_type_o(u_o), .j_type_o(j_o),
      .imm_o(imm_o), .pc_o(pc_o), .illegal_o(illegal_o)
   );

   decode_stage #(.XLEN(64), .RV64W(1'b0)) dut_nw (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(nw_in_ready),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(nw_out_valid), .out_ready_i(out_ready_i),
      .rs1_o(nw_rs1), .rs2_o(nw_rs2), .rd_o(nw_rd), .op_o(nw_op),
      .funct3_o(nw_f3), .funct7_o(nw_f7),
      .r_type_o(nw_r), .i_type_o(nw_i), .s_type_o(nw_s),
      .b_type_o(nw_b), .u_type_o(nw_u), .j_type_o(nw_j),
      .imm_o(nw_imm), .pc_o(nw_pc), .illegal_o(nw_ill)
   );

   function automatic vec_t mk(input logic [31:0] ins, input logic [5:0] c,
                               input logic [63:0] im, input bit un, input int idx);
      vec_t v;
      v.instr = ins;
      v.pc    = 64'hFFFF_FFFF_0000_1000 + 64'(idx * 4);
      v.cls   = c;
      v.imm   = im;
      v.unrec = un;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_entry(input vec_t e);
      logic        exp_ill;
      logic [31:0] ins;
      ins = e.instr;
`ifdef DECODE_ILLEGAL_EN
      exp_ill = e.unrec || (ins[1:0] != 2'b11);
`else
      exp_ill = 1'b0;
`endif
      check("fields", {rs1_o, rs2_o, rd_o, op_o, funct3_o, funct7_o},
            {ins[19:15], ins[24:20], ins[11:7], ins[6:0], ins[14:12], ins[31:25]});
      check("class", {r_o, i_o, s_o, b_o, u_o, j_o}, e.cls);
      check("imm", imm_o, e.imm);
      check("pc", pc_o, e.pc);
      check("illegal", illegal_o, exp_ill);
      if (ins[6:0] == 7'b0111011 || ins[6:0] == 7'b0011011) begin
         check("nw_class", {nw_r, nw_i, nw_s, nw_b, nw_u, nw_j}, 6'b0);
         check("nw_imm", nw_imm, 64'h0);
      end else begin
         check("nw_class", {nw_r, nw_i, nw_s, nw_b, nw_u, nw_j}, e.cls);
      end
   endtask

   // Scoreboard: predict the upcoming edge from inputs/outputs sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
      end else begin
         if (out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got pc 0x%0h expected none", pc_o);
            end else begin
               check_entry(q.pop_front());
            end
         end
         if (flush_i) q.delete();
         else if (in_valid_i && in_ready_o) q.push_back(cur);
      end
   end

   task automatic send(input vec_t v);
      bit done;
      done       = 1'b0;
      cur        = v;
      instr_i    = v.instr;
      pc_i       = v.pc;
      in_valid_i = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready_o) done = 1'b1;
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic check_reset_state(input string name);
      @(negedge clk);
      check(name, {in_ready_o, out_valid_o, r_o, i_o, s_o, b_o, u_o, j_o, illegal_o,
                   rd_o, rs1_o, rs2_o},
            {1'b1, 1'b0, 7'b0, 15'b0});
      check({name, "_data"}, imm_o | pc_o, 64'h0);
   endtask

   logic [63:0] hold_imm, hold_pc;
   logic [4:0]  hold_rd;

   initial begin
      tbl[0]  = mk(32'hFFF00093, 6'b010000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);  // ADDI x1,x0,-1
      tbl[1]  = mk(32'h800000B7, 6'b000010, 64'hFFFF_FFFF_8000_0000, 0, 1);  // LUI
      tbl[2]  = mk(32'hFE000EE3, 6'b000100, 64'hFFFF_FFFF_FFFF_FFFC, 0, 2);  // BEQ -4
      tbl[3]  = mk(32'h0010006F, 6'b000001, 64'h800, 0, 3);                  // JAL +2048
      tbl[4]  = mk(32'h003100BB, 6'b100000, 64'h0, 0, 4);                    // ADDW
      tbl[5]  = mk(32'hFE512C23, 6'b001000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 5);  // SW -8
      tbl[6]  = mk(32'h002081B3, 6'b100000, 64'h0, 0, 6);                    // ADD
      tbl[7]  = mk(32'h1234507F, 6'b000000, 64'h0, 1, 7);                    // opcode 0x7F
      tbl[8]  = mk(32'h01012083, 6'b010000, 64'h10, 0, 8);                   // LW 16
      tbl[9]  = mk(32'h12345297, 6'b000010, 64'h1234_5000, 0, 9);            // AUIPC
      tbl[10] = mk(32'h00008067, 6'b010000, 64'h0, 0, 10);                   // JALR
      tbl[11] = mk(32'h00000001, 6'b000000, 64'h0, 1, 11);                   // low bits 01
      tbl[12] = mk(32'h0010809B, 6'b010000, 64'h1, 0, 12);                   // ADDIW
      tbl[13] = mk(32'hFFDFF0EF, 6'b000001, 64'hFFFF_FFFF_FFFF_FFFC, 0, 13); // JAL -4

      reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      instr_i = '0; pc_i = '0; cur = tbl[0];
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_state("reset");

      // Back-to-back stream through the table.
      @(posedge clk); #1;
      for (int i = 0; i < 14; i++) send(tbl[i]);
      repeat (3) @(negedge clk);
      check("stream_drained", 64'(q.size()), 64'd0);

      // Backpressure: two accepted, third stalls, outputs frozen.
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      send(tbl[0]);
      send(tbl[2]);
      cur = tbl[3]; instr_i = tbl[3].instr; pc_i = tbl[3].pc; in_valid_i = 1'b1;
      @(negedge clk);
      check("bp_full", {in_ready_o, out_valid_o}, 2'b01);
      hold_imm = imm_o; hold_pc = pc_o; hold_rd = rd_o;
      repeat (3) @(negedge clk);
      check("bp_stable", {imm_o, pc_o}, {hold_imm, hold_pc});
      check("bp_stable_rd_ready", {rd_o, in_ready_o}, {hold_rd, 1'b0});
      check("bp_main_is_first", pc_o, tbl[0].pc);
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      @(negedge clk);
      check("b2b_first", {out_valid_o, pc_o}, {1'b1, tbl[0].pc});
      @(negedge clk);
      check("b2b_second", {out_valid_o, pc_o, in_ready_o}, {1'b1, tbl[2].pc, 1'b1});
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check("bp_drained", 64'(q.size()), 64'd0);

      // Flush while full, with a simultaneous push that must vanish.
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      send(tbl[5]);
      send(tbl[8]);
      cur = tbl[9]; instr_i = tbl[9].instr; pc_i = tbl[9].pc;
      in_valid_i = 1'b1; flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0; in_valid_i = 1'b0;
      @(negedge clk);
      check("flush_empty", {in_ready_o, out_valid_o}, 2'b10);
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      repeat (4) @(negedge clk);
      check("flush_stays_empty", out_valid_o, 1'b0);

      // Reset in the middle of operation.
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      send(tbl[1]);
      send(tbl[4]);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_state("mid_reset");

      // Final drain with a bounded wait.
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      send(tbl[13]);
      for (int k = 0; k < 20 && (q.size() != 0 || out_valid_o); k++) @(negedge clk);
      check("final_drain", {64'(q.size()), 63'd0, out_valid_o}, 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
